// File: rtl/fifo_rd_pack.sv
// Read-side width upsizer: drains DW-bit FWFT words from fifo_sync and packs
// RATIO of them into one DW*RATIO-bit valid/ready word, with flush/timeout partials.

module fifo_rd_pack_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] d,
  input  logic          keep,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qm
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

  // Lanes at or above the current count may hold stale data from an older word.
  assign qm = keep ? q : '0;
endmodule

module fifo_rd_pack #(
  parameter int DW      = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [DW*RATIO-1:0]   m_data,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_valid,
  input  logic                  m_ready
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int AL = RATIO - 1;

  logic [AL-1:0][DW-1:0]   acc;
  logic [RATIO-1:0][DW-1:0] nxt_data;
  logic [RATIO-1:0]        nxt_keep;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idle;
  logic                    out_free, last, timed_out, flush_req;
  logic                    pop, do_flush, load;

  assign out_free   = !m_valid || m_ready;
  assign last       = (cnt == CW'(RATIO - 1));
  assign timed_out  = (TIMEOUT != 0) && (idle == IW'(TIMEOUT));
  assign flush_req  = (cnt != '0) && (flush || timed_out);
  assign fifo_rd_en = !rst && !fifo_empty && !flush_req && (!last || out_free);
  assign pop        = fifo_rd_en;
  assign do_flush   = flush_req && out_free;
  assign load       = (pop && last) || do_flush;

  generate
    for (genvar i = 0; i < AL; i++) begin : g_lane
      fifo_rd_pack_lane #(.DW(DW)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .ld   (pop && (cnt == CW'(i))),
        .d    (fifo_dout),
        .keep (!do_flush || (CW'(i) < cnt)),
        .q    (acc[i]),
        .qm   (nxt_data[i])
      );
      assign nxt_keep[i] = !do_flush || (CW'(i) < cnt);
    end
  endgenerate

  // Top lane only ever comes straight from the FIFO on a full-word pop.
  assign nxt_data[AL] = do_flush ? '0 : fifo_dout;
  assign nxt_keep[AL] = !do_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_valid <= 1'b0;
      cnt     <= '0;
      idle    <= '0;
    end else begin
      if (load) begin
        m_data  <= nxt_data;
        m_keep  <= nxt_keep;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (load)     cnt <= '0;
      else if (pop) cnt <= cnt + CW'(1);

      if (load || pop || (cnt == '0)) idle <= '0;
      else if (idle != IW'(TIMEOUT))   idle <= idle + IW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack: FWFT FIFO model, output capture, hand-computed words.

module tb_fifo_rd_pack;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, m_ready = 1'b0;
  logic [7:0]  mem [64];
  int          rp = 0, wp = 0;
  logic [7:0]  fifo_dout;
  logic        fifo_empty, fifo_rd_en;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;

  // second instance with auto-flush disabled
  logic        e1 = 1'b1;
  logic [7:0]  d1 = 8'h55;
  logic        rd1, v1;
  logic [31:0] md1;
  logic [3:0]  mk1;

  assign fifo_empty = (rp == wp);
  assign fifo_dout  = mem[rp % 64];

  fifo_rd_pack #(.DW(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready));

  fifo_rd_pack #(.DW(8), .RATIO(4), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .fifo_dout(d1), .fifo_empty(e1),
    .fifo_rd_en(rd1), .flush(1'b0), .m_data(md1), .m_keep(mk1),
    .m_valid(v1), .m_ready(1'b1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fifo_rd_en) rp <= rp + 1;

  logic [31:0] cap_d[$];
  logic [3:0]  cap_k[$];
  int          cap_t[$];
  int          last_pop = 0, v1cnt = 0, r1cnt = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      cap_d.push_back(m_data);
      cap_k.push_back(m_keep);
      cap_t.push_back(cyc);
    end
    if (fifo_rd_en) last_pop = cyc + 1;
    if (v1)  v1cnt++;
    if (rd1) r1cnt++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] capd(input int k);
    return (k < cap_d.size()) ? cap_d[k] : 32'hDEADBEEF;
  endfunction
  function automatic logic [3:0] capk(input int k);
    return (k < cap_k.size()) ? cap_k[k] : 4'hX;
  endfunction
  function automatic int capt(input int k);
    return (k < cap_t.size()) ? cap_t[k] : -1000;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic push(input logic [7:0] b);
    mem[wp % 64] = b;
    wp++;
  endtask
  task automatic clr();
    cap_d.delete(); cap_k.delete(); cap_t.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int w0;

  initial begin
    steps(2);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data",  m_data,  0);
    chk("rst_keep",  m_keep,  0);
    chk("rst_rden",  fifo_rd_en, 0);

    // full words, back-to-back
    step(); rst = 1'b0; clr(); m_ready = 1'b1;
    for (int b = 1; b <= 8; b++) push(8'(b));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk($sformatf("t1_rden%0d", i), fifo_rd_en, 1);
    end
    @(negedge clk); chk("t1_rden_end", fifo_rd_en, 0);
    steps(3);
    chk("t1_n",  cap_d.size(), 2);
    chk("t1_d0", capd(0), 32'h04030201);
    chk("t1_k0", capk(0), 4'hF);
    chk("t1_d1", capd(1), 32'h08070605);
    chk("t1_k1", capk(1), 4'hF);
    chk("t1_gap", capt(1) - capt(0), 4);

    // backpressure
    clr(); m_ready = 1'b0; w0 = wp;
    for (int b = 1; b <= 8; b++) push(8'(b));
    steps(12);
    @(negedge clk);
    chk("t2_pops",  rp - w0, 7);
    chk("t2_rden",  fifo_rd_en, 0);
    chk("t2_valid", m_valid, 1);
    chk("t2_hold0", m_data, 32'h04030201);
    chk("t2_keep",  m_keep, 4'hF);
    steps(3);
    @(negedge clk);
    chk("t2_hold1", m_data, 32'h04030201);
    step(); m_ready = 1'b1;
    @(negedge clk); chk("t2_rden_go", fifo_rd_en, 1);
    steps(3);
    chk("t2_n",   cap_d.size(), 2);
    chk("t2_d0",  capd(0), 32'h04030201);
    chk("t2_d1",  capd(1), 32'h08070605);
    chk("t2_gap", capt(1) - capt(0), 1);

    // timeout flush
    clr(); push(8'hAA); push(8'hBB);
    steps(25);
    chk("t3_n",   cap_d.size(), 1);
    chk("t3_d",   capd(0), 32'h0000BBAA);
    chk("t3_k",   capk(0), 4'h3);
    chk("t3_lat", capt(0) - last_pop, 17);

    // no auto-flush with TIMEOUT=0
    v1cnt = 0; r1cnt = 0; e1 = 1'b0;
    steps(2); e1 = 1'b1;
    steps(100);
    chk("t3_to0_pops",  r1cnt, 2);
    chk("t3_to0_valid", v1cnt, 0);

    // explicit flush
    clr(); push(8'h11); push(8'h22); push(8'h33);
    steps(5); flush = 1'b1;
    step();   flush = 1'b0;
    steps(3);
    chk("t4_n", cap_d.size(), 1);
    chk("t4_d", capd(0), 32'h00332211);
    chk("t4_k", capk(0), 4'h7);
    flush = 1'b1; step(); flush = 1'b0;
    steps(3);
    @(negedge clk);
    chk("t4_empty_n",     cap_d.size(), 1);
    chk("t4_empty_valid", m_valid, 0);

    // flush vs data
    clr(); push(8'h41); push(8'h42);
    steps(3);
    push(8'h43); push(8'h44); push(8'h45); push(8'h46); flush = 1'b1;
    @(negedge clk); chk("t5_rden_blk", fifo_rd_en, 0);
    step(); flush = 1'b0;
    steps(8);
    chk("t5_n",  cap_d.size(), 2);
    chk("t5_d0", capd(0), 32'h00004241);
    chk("t5_k0", capk(0), 4'h3);
    chk("t5_d1", capd(1), 32'h46454443);
    chk("t5_k1", capk(1), 4'hF);

    // reset mid-operation with stalled output and partial
    m_ready = 1'b0;
    for (int b = 8'h21; b <= 8'h26; b++) push(8'(b));
    steps(10);
    @(negedge clk); chk("t6_pre_valid", m_valid, 1);
    step(); rst = 1'b1;
    push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
    @(negedge clk); chk("t6_rden_rst", fifo_rd_en, 0);
    step(); rst = 1'b0; m_ready = 1'b1; clr();
    @(negedge clk);
    chk("t6_valid", m_valid, 0);
    chk("t6_keep",  m_keep, 0);
    chk("t6_data",  m_data, 0);
    steps(8);
    chk("t6_n", cap_d.size(), 1);
    chk("t6_d", capd(0), 32'h0D0C0B0A);
    chk("t6_k", capk(0), 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_pack.md
# fifo_rd_pack

Read-side width upsizer that sits directly downstream of `fifo_sync`. It drains `DW`-bit words from the FWFT read port and packs `RATIO` consecutive words into one `DW*RATIO`-bit word. The packed word is presented on a valid/ready master interface. Partial words leave the block on an explicit `flush` or after a programmable idle timeout, and carry a per-lane keep mask.

## Interface
- `DW`, 8: FIFO word width in bits.
- `RATIO`, 4: input words per output word; ≥2.
- `TIMEOUT`, 16: idle cycles with a partial word held before auto-flush; 0 disables auto-flush.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_dout`  in  DW  FWFT data; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop request (combinational).
- `flush`  in  1  level request to emit the held partial word.
- `m_data`  out  DW*RATIO  packed word; lane 0 (LSBs) holds the oldest input word.
- `m_keep`  out  RATIO  lane-valid mask; bit i covers `m_data[i*DW+:DW]`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.

## Operation
- State:
  - accumulator `acc` of RATIO-1 lanes;
  - lane count `cnt` (0..RATIO-1);
  - idle counter `idle` (0..TIMEOUT, saturating);
  - output register `m_data`/`m_keep`/`m_valid`.
- `out_free` = !m_valid || m_ready.
- `flush_req` = cnt≠0 && (flush || (TIMEOUT≠0 && idle==TIMEOUT)).
- Pop rule: `fifo_rd_en` = !rst && !fifo_empty && !flush_req && (cnt<RATIO-1 || out_free).
  - `fifo_rd_en` is never high while `fifo_empty`=1.
  - The word is consumed at the edge where `fifo_rd_en`=1.
- Pop with cnt<RATIO-1: `fifo_dout` goes into lane `cnt`; cnt+1; idle cleared.
- Pop with cnt==RATIO-1 (out_free guaranteed):
  - m_data={fifo_dout, acc}; m_keep=all ones; m_valid=1.
  - cnt=0; idle=0.
- Flush, when `flush_req` && out_free:
  - m_data gets lanes 0..cnt-1 from acc; unused lanes are 0.
  - m_keep=(1<<cnt)-1; m_valid=1; cnt=0; idle=0.
- Flush blocked: if `flush_req` && !out_free, hold; no pops until the flush completes.
- `flush` with cnt==0 has no effect; no empty words are ever emitted.
- Idle counter:
  - increments on each cycle with cnt≠0 and no pop, saturating at TIMEOUT;
  - held at 0 while cnt==0.
- Output release: when m_valid && m_ready and no new load in the same cycle, m_valid=0.
  - Load and accept in the same cycle leaves m_valid=1 with the new word.
- Output stability: m_data/m_keep are stable while m_valid && !m_ready.
- Internal width:
  - cnt is clog2(RATIO) bits;
  - idle is clog2(TIMEOUT+1) bits (min 1).

## Timing
- Reset, sampled at the edge:
  - m_valid=0, m_data=0, m_keep=0;
  - cnt=0, idle=0, acc=0;
  - fifo_rd_en=0 while rst=1.
- Reset mid-operation discards any partial and pending output word; the next pop lands in lane 0.
- Latency: m_valid rises in the cycle after the edge that pops the RATIO-th word.
- Throughput: one input word per cycle sustained while m_ready=1; no bubble between output words.
- Backpressure: with m_ready=0 the block accepts RATIO-1 further words, then holds `fifo_rd_en`=0.
- Auto-flush: m_valid rises TIMEOUT+1 cycles after the last pop into a partial word, provided out_free.
- Combinational paths:
  - `fifo_rd_en` depends combinationally on `fifo_empty`, `m_ready` and `flush`;
  - no other combinational input-to-output path.
- Data capture: `fifo_sync` updates `dout` in the cycle after a pop; the block samples `fifo_dout` only at edges with `fifo_rd_en`=1.

## Test plan
All scenarios use DW=8, RATIO=4, TIMEOUT=16 unless stated.
- **Full words:** FIFO holds 0x01..0x08, m_ready=1 → fifo_rd_en high 8 consecutive cycles; outputs 0x04030201 then 0x08070605, keep=0xF each, back-to-back.
- **Backpressure:** same 8 words, m_ready=0 → first word held stable, fifo_rd_en drops after 7 pops. Raising m_ready → 8th pop, second word 0x08070605 follows on the next cycle.
- **Timeout flush:** push 0xAA, 0xBB, FIFO then empty → m_valid rises 17 cycles after the last pop with m_data=0x0000BBAA, keep=0x3. With TIMEOUT=0, no output appears after 100 cycles.
- **Explicit flush:** 3 words 0x11,0x22,0x33, pulse flush → m_data=0x00332211, keep=0x7. Flush pulse with cnt=0 → no m_valid.
- **Flush vs data:** flush held high while the FIFO is non-empty and cnt=2 → fifo_rd_en=0 that cycle, partial word emitted, pops resume into lane 0.
- **Reset mid-operation:** cnt=2 with a stalled output (m_ready=0), rst for 1 cycle → m_valid=0, m_keep=0. The next 4 words 0x0A..0x0D produce 0x0D0C0B0A.
